// File: rtl/pkg_rv32_types.sv
// Shared RV32 decode types: widths, opcode encodings, immediate formats
// and the stage payload carried from decode towards execute.
package pkg_rv32_types;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned REG_W = 5;
  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LUI      = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL      = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR     = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_LOAD     = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [OPC_W-1:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_STORE    = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP       = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_type_e;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  imm;
    imm_type_e        imm_type;
    logic [REG_W-1:0] rd;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic             illegal;
  } id_payload_t;

  localparam id_payload_t ID_PAYLOAD_RST = '{
    pc:       '0,
    imm:      '0,
    imm_type: IMM_NONE,
    rd:       '0,
    rs1:      '0,
    rs2:      '0,
    illegal:  1'b0
  };

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32 immediate extraction and sign extension.
// The opcode field is not needed here, so only instr[31:7] is taken.
module rv32_imm_gen
  import pkg_rv32_types::*;
(
  input  logic [XLEN-1:7] instr,
  input  imm_type_e       imm_type,
  output logic [XLEN-1:0] imm_c
);

  always_comb begin
    imm_c = '0;
    case (imm_type)
      IMM_I: imm_c = {{20{instr[31]}}, instr[31:20]};
      IMM_S: imm_c = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm_c = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                      instr[11:8], 1'b0};
      IMM_U: imm_c = {instr[31:12], 12'b0};
      IMM_J: imm_c = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                      instr[30:21], 1'b0};
      default: imm_c = '0;
    endcase
  end

endmodule

// File: rtl/rv32_id_stage.sv
// RV32 decode stage: inline opcode decode plus immediate generation,
// buffered by a main register and one skid register for full-rate flow.
module rv32_id_stage
  import pkg_rv32_types::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_valid,
  input  logic [XLEN-1:0]   if_instr,
  input  logic [XLEN-1:0]   if_pc,
  output logic              if_ready,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              id_valid,
  output logic [XLEN-1:0]   id_pc,
  output logic [XLEN-1:0]   id_imm,
  output imm_type_e         id_imm_type,
  output logic [REG_W-1:0]  id_rd,
  output logic [REG_W-1:0]  id_rs1,
  output logic [REG_W-1:0]  id_rs2,
  output logic              id_illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_ONE,
    ST_FULL
  } state_e;

  state_e          state, state_d;
  id_payload_t     m, s, dec_c;
  imm_type_e       imm_type_c;
  logic            illegal_c;
  logic [XLEN-1:0] imm_c;
  logic            accept, fire;
  logic            load_m_dec, load_m_skid, load_s;

  // Opcode to immediate format; anything unrecognised is illegal.
  always_comb begin
    imm_type_c = IMM_NONE;
    illegal_c  = 1'b0;
    case (if_instr[OPC_W-1:0])
      OPC_LUI, OPC_AUIPC:                 imm_type_c = IMM_U;
      OPC_JAL:                            imm_type_c = IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM,
      OPC_SYSTEM, OPC_MISC_MEM:           imm_type_c = IMM_I;
      OPC_BRANCH:                         imm_type_c = IMM_B;
      OPC_STORE:                          imm_type_c = IMM_S;
      OPC_OP:                             imm_type_c = IMM_NONE;
      default: begin
        imm_type_c = IMM_NONE;
        illegal_c  = 1'b1;
      end
    endcase
  end

  rv32_imm_gen u_imm_gen (
    .instr    (if_instr[XLEN-1:7]),
    .imm_type (imm_type_c),
    .imm_c    (imm_c)
  );

  always_comb begin
    dec_c.pc       = if_pc;
    dec_c.imm      = imm_c;
    dec_c.imm_type = imm_type_c;
    dec_c.rd       = if_instr[11:7];
    dec_c.rs1      = if_instr[19:15];
    dec_c.rs2      = if_instr[24:20];
    dec_c.illegal  = illegal_c;
  end

  assign accept = if_valid && if_ready;
  assign fire   = id_valid && ex_ready;

  // Next state and register load selects; flush overrides everything.
  always_comb begin
    state_d     = state;
    load_m_dec  = 1'b0;
    load_m_skid = 1'b0;
    load_s      = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            load_m_dec = 1'b1;
            state_d    = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && fire) begin
            load_m_dec = 1'b1;
          end else if (fire) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            load_s  = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (fire) begin
            load_m_skid = 1'b1;
            state_d     = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_EMPTY;
      id_valid <= 1'b0;
      if_ready <= 1'b0;
      m        <= ID_PAYLOAD_RST;
      s        <= ID_PAYLOAD_RST;
    end else begin
      state    <= state_d;
      id_valid <= (state_d != ST_EMPTY);
      if_ready <= (state_d != ST_FULL);
      if (load_m_dec) begin
        m <= dec_c;
      end else if (load_m_skid) begin
        m <= s;
      end
      if (load_s) begin
        s <= dec_c;
      end
    end
  end

  assign id_pc       = m.pc;
  assign id_imm      = m.imm;
  assign id_imm_type = m.imm_type;
  assign id_rd       = m.rd;
  assign id_rs1      = m.rs1;
  assign id_rs2      = m.rs2;
  assign id_illegal  = m.illegal;

endmodule

// File: tb/tb_rv32_id_stage.sv
// Scoreboard bench for rv32_id_stage: the driver queues expected decodes
// on acceptance, the monitor pops and compares on every retirement.
module tb_rv32_id_stage;
  import pkg_rv32_types::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              if_valid;
  logic [XLEN-1:0]   if_instr;
  logic [XLEN-1:0]   if_pc;
  logic              if_ready;
  logic              flush;
  logic              ex_ready;
  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_imm;
  imm_type_e         id_imm_type;
  logic [REG_W-1:0]  id_rd;
  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic              id_illegal;

  rv32_id_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .if_valid    (if_valid),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .if_ready    (if_ready),
    .flush       (flush),
    .ex_ready    (ex_ready),
    .id_valid    (id_valid),
    .id_pc       (id_pc),
    .id_imm      (id_imm),
    .id_imm_type (id_imm_type),
    .id_rd       (id_rd),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_illegal  (id_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] imm;
    imm_type_e   typ;
    logic        ill;
    int          exp_cyc;
    bit          consec;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          last_fire = -10;
  int          n_tests = 0;
  int          n_fail = 0;
  bit          stall_q = 1'b0;
  logic [31:0] pc_q, imm_q;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every retirement must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && id_valid && ex_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_emit: got pc 0x%08h expected no output (t=%0t)", id_pc, $time);
      end else begin
        e = sb.pop_front();
        chk("pc", id_pc, e.pc);
        chk("imm", id_imm, e.imm);
        chk("imm_type", 32'(id_imm_type), 32'(e.typ));
        chk("illegal", 32'(id_illegal), 32'(e.ill));
        chk("rd", 32'(id_rd), 32'(e.instr[11:7]));
        chk("rs1", 32'(id_rs1), 32'(e.instr[19:15]));
        chk("rs2", 32'(id_rs2), 32'(e.instr[24:20]));
        if (e.exp_cyc >= 0) chk("latency", 32'(cyc), 32'(e.exp_cyc));
        if (e.consec) chk("consecutive", 32'(cyc), 32'(last_fire + 1));
      end
      last_fire = cyc;
    end
    if (rst_n && id_valid && !ex_ready) begin
      if (stall_q) begin
        chk("stall_pc_stable", id_pc, pc_q);
        chk("stall_imm_stable", id_imm, imm_q);
      end
      stall_q = 1'b1;
      pc_q    = id_pc;
      imm_q   = id_imm;
    end else begin
      stall_q = 1'b0;
    end
  end

  // Present one instruction, wait (bounded) for acceptance, queue its expectation.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] imm,
                      input imm_type_e typ, input logic ill, input bit lat, input bit consec);
    exp_t e;
    bit   ok = 1'b0;
    if_valid = 1'b1;
    if_instr = instr;
    if_pc    = pc;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (if_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_tests++;
      n_fail++;
      $display("FAIL send_timeout: got no if_ready for pc 0x%08h expected acceptance", pc);
    end else begin
      e.instr   = instr;
      e.pc      = pc;
      e.imm     = imm;
      e.typ     = typ;
      e.ill     = ill;
      e.exp_cyc = lat ? cyc + 1 : -1;
      e.consec  = consec;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected completion");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    if_valid = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    if_instr = '0;
    if_pc    = '0;
    repeat (2) @(negedge clk);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_if_ready", 32'(if_ready), 32'd0);
    chk("rst_pc", id_pc, 32'd0);
    chk("rst_imm", id_imm, 32'd0);
    chk("rst_imm_type", 32'(id_imm_type), 32'(IMM_NONE));
    chk("rst_illegal", 32'(id_illegal), 32'd0);
    chk("rst_rd", 32'(id_rd), 32'd0);
    chk("rst_rs1", 32'(id_rs1), 32'd0);
    chk("rst_rs2", 32'(id_rs2), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("if_ready_after_reset", 32'(if_ready), 32'd1);
    chk("id_valid_after_reset", 32'(id_valid), 32'd0);
    @(posedge clk);
    #1;

    // Single ADDI, then a back-to-back U/J/B stream.
    send(32'hFFF00093, 32'h100, 32'hFFFFFFFF, IMM_I, 1'b0, 1'b1, 1'b0);
    idle(1);
    send(32'h12345537, 32'h104, 32'h12345000, IMM_U, 1'b0, 1'b1, 1'b0);
    send(32'hFFDFF06F, 32'h108, 32'hFFFFFFFC, IMM_J, 1'b0, 1'b1, 1'b1);
    send(32'hFE000EE3, 32'h10C, 32'hFFFFFFFC, IMM_B, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Remaining formats and illegal opcodes.
    send(32'h00000000, 32'h110, 32'h00000000, IMM_NONE, 1'b1, 1'b1, 1'b0);
    send(32'hFFFFFFFF, 32'h114, 32'h00000000, IMM_NONE, 1'b1, 1'b1, 1'b0);
    send(32'h00112223, 32'h118, 32'h00000004, IMM_S, 1'b0, 1'b1, 1'b0);
    send(32'h002081B3, 32'h11C, 32'h00000000, IMM_NONE, 1'b0, 1'b1, 1'b0);
    send(32'hFFC12083, 32'h120, 32'hFFFFFFFC, IMM_I, 1'b0, 1'b1, 1'b0);
    send(32'hFFFFF117, 32'h124, 32'hFFFFF000, IMM_U, 1'b0, 1'b1, 1'b0);
    send(32'h0FF0000F, 32'h128, 32'h000000FF, IMM_I, 1'b0, 1'b1, 1'b0);
    send(32'h00000073, 32'h12C, 32'h00000000, IMM_I, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Back-pressure: fill M and S, hold C, then drain in order.
    ex_ready = 1'b0;
    send(32'h00500113, 32'h200, 32'h00000005, IMM_I, 1'b0, 1'b0, 1'b0);
    send(32'h00A00193, 32'h204, 32'h0000000A, IMM_I, 1'b0, 1'b0, 1'b1);
    if_valid = 1'b1;
    if_instr = 32'h00F00213;
    if_pc    = 32'h208;
    @(negedge clk);
    chk("full_if_ready", 32'(if_ready), 32'd0);
    chk("full_id_valid", 32'(id_valid), 32'd1);
    chk("full_id_pc", id_pc, 32'h200);
    @(negedge clk);
    chk("full_hold_if_ready", 32'(if_ready), 32'd0);
    chk("full_hold_id_pc", id_pc, 32'h200);
    @(posedge clk);
    #1;
    ex_ready = 1'b1;
    send(32'h00F00213, 32'h208, 32'h0000000F, IMM_I, 1'b0, 1'b0, 1'b1);
    idle(3);

    // Flush while FULL with a live incoming instruction.
    ex_ready = 1'b0;
    send(32'h00500113, 32'h300, 32'h00000005, IMM_I, 1'b0, 1'b0, 1'b0);
    send(32'h00A00193, 32'h304, 32'h0000000A, IMM_I, 1'b0, 1'b0, 1'b0);
    if_valid = 1'b1;
    if_instr = 32'h00F00213;
    if_pc    = 32'h308;
    flush    = 1'b1;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    if_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_id_valid", 32'(id_valid), 32'd0);
    chk("flush_if_ready", 32'(if_ready), 32'd1);
    @(posedge clk);
    #1;
    ex_ready = 1'b1;
    idle(3);
    send(32'h12345537, 32'h310, 32'h12345000, IMM_U, 1'b0, 1'b1, 1'b0);
    idle(2);

    // Asynchronous reset while FULL.
    ex_ready = 1'b0;
    send(32'h00500113, 32'h400, 32'h00000005, IMM_I, 1'b0, 1'b0, 1'b0);
    send(32'h00A00193, 32'h404, 32'h0000000A, IMM_I, 1'b0, 1'b0, 1'b0);
    if_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_id_valid", 32'(id_valid), 32'd0);
    chk("async_rst_if_ready", 32'(if_ready), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_if_ready", 32'(if_ready), 32'd1);
    chk("post_rst_id_valid", 32'(id_valid), 32'd0);
    @(posedge clk);
    #1;
    send(32'hFFDFF06F, 32'h500, 32'hFFFFFFFC, IMM_J, 1'b0, 1'b1, 1'b0);
    idle(3);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rv32_id_stage.md
RV32_ID_STAGE -- requirements
Module: rv32_id_stage

Interface
REQ-001 Parameters: none; widths SHALL come from pkg_rv32_types (XLEN = 32).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 if_valid  input  1  fetch presents an instruction.
REQ-005 if_instr  input  XLEN  instruction word.
REQ-006 if_pc  input  XLEN  PC of if_instr.
REQ-007 if_ready  output  1  stage can accept; driven from a register.
REQ-008 flush  input  1  synchronous kill of all held and incoming instructions.
REQ-009 ex_ready  input  1  execute stage accepts id outputs.
REQ-010 id_valid  output  1  id_* outputs hold a decoded instruction.
REQ-011 id_pc  output  XLEN  PC of the decoded instruction.
REQ-012 id_imm  output  XLEN  sign-extended immediate.
REQ-013 id_imm_type  output  imm_type_e  selected immediate format.
REQ-014 id_rd / id_rs1 / id_rs2  output  5 each  instr[11:7] / [19:15] / [24:20].
REQ-015 id_illegal  output  1  opcode not in the supported set.

Function
REQ-016 Opcode instr[6:0] to format: 0110111/0010111 -> U; 1101111 -> J; 1100111, 0000011, 0010011, 1110011, 0001111 -> I; 1100011 -> B; 0100011 -> S; 0110011 -> IMM_NONE.
REQ-017 Any other opcode SHALL set illegal = 1 and select IMM_NONE.
REQ-018 IMM_NONE SHALL yield id_imm = 0.
REQ-019 Decode and immediate generation SHALL occur combinationally on the if_* inputs; results SHALL be captured in stage registers.
REQ-020 Latency: an instruction accepted in cycle N SHALL appear on id_* in cycle N+1.
REQ-021 Acceptance: accept = if_valid && if_ready.
REQ-022 Retirement: fire = id_valid && ex_ready.
REQ-023 Storage SHALL be a main register M (drives id_*) plus one skid register S.
REQ-024 States: EMPTY (M, S invalid), ONE (M valid), FULL (M and S valid).
REQ-025 EMPTY: accept -> load M, go to ONE.
REQ-026 ONE: accept && fire -> reload M, stay ONE.
REQ-027 ONE: fire only -> EMPTY.
REQ-028 ONE: accept only -> load S, go to FULL.
REQ-029 ONE: neither -> hold.
REQ-030 FULL: fire -> M <= S, go to ONE; otherwise hold.
REQ-031 FULL SHALL never accept, because if_ready is 0 in FULL.
REQ-032 if_ready SHALL equal (next state != FULL), registered; it is 1 in EMPTY and ONE.
REQ-033 id_* SHALL be stable while id_valid && !ex_ready.
REQ-034 Program order SHALL be preserved across the skid path.
REQ-035 flush SHALL have priority over accept and fire: next state EMPTY, the same-cycle input is dropped, and if_ready is 1 the following cycle.
REQ-036 When id_valid = 0, id_* data values are don't-care, except as stated in REQ-038.

Reset
REQ-037 On rst_n low: state EMPTY, id_valid 0, if_ready 0 during reset, if_ready 1 from the first clock after deassertion.
REQ-038 On rst_n low: id_pc, id_imm, rd, rs1, rs2 = 0; id_imm_type = IMM_NONE; id_illegal = 0.
REQ-039 Reset mid-operation SHALL discard M and S without emitting them.

Structure
REQ-040 imm_type_e (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE), XLEN and opcode localparams SHALL live in pkg_rv32_types.
REQ-041 The stage-state enum SHALL be local to the module.
REQ-042 Immediate extraction SHALL be the existing sub-module rv32_imm_gen, instantiated once on the if_* path.
REQ-043 Opcode decode SHALL be inline.

Verification
REQ-044 ADDI 0xFFF00093 accepted cycle N, ex_ready = 1 -> cycle N+1: id_valid 1, id_imm 0xFFFFFFFF, IMM_I, rd 1, rs1 0.
REQ-045 Stream LUI 0x12345537, JAL 0xFFDFF06F, BEQ 0xFE000EE3 back-to-back -> imm 0x12345000, 0xFFFFFFFC, 0xFFFFFFFC in order; U, J, B; one per cycle.
REQ-046 ex_ready = 0, send A, B, C -> A on id_*, B in S, if_ready 0, C held; raise ex_ready -> A, B, C emitted on consecutive cycles.
REQ-047 Instruction 0x00000000 -> id_illegal 1, id_imm 0, IMM_NONE.
REQ-048 In FULL assert flush with if_valid = 1 -> next cycle id_valid 0, if_ready 1, none of the three instructions emitted.
REQ-049 Drop rst_n asynchronously while FULL -> id_valid falls immediately; after release, first new instruction emitted with 1-cycle latency.
